// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared definitions for the LED pattern engine.
//   led_seq_mode_t : 2-bit pattern select (COUNT, SCAN, BREATHE, OFF)
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT   = 2'd0,
        MODE_SCAN    = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_OFF     = 2'd3
    } led_seq_mode_t;

endpackage : led_seq_pkg

// File: rtl/led_prescaler.sv
// led_prescaler: step-rate divider for the LED sequencer.
//   clk50 : 50 MHz clock (rising edge)
//   rst   : synchronous active-high reset, clears div_cnt
//   en    : count enable; low freezes div_cnt
//   tick  : high while div_cnt sits at TICK_DIV-1 with en high, i.e. on
//           the cycle whose closing edge wraps the divider. It is left
//           unregistered so the top level can advance the pattern and
//           register its own step_tick on that same edge.
module led_prescaler #(
    parameter int TICK_DIV = 16777216
) (
    input  logic clk50,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] DIV_ZERO = CW'(0);
    localparam logic [CW-1:0] DIV_ONE  = CW'(1);

    logic [CW-1:0] div_cnt_r;

    assign tick = en && (div_cnt_r == DIV_LAST);

    // Divider counter: wraps at TICK_DIV-1, holds while disabled.
    always_ff @(posedge clk50) begin
        if (rst) begin
            div_cnt_r <= DIV_ZERO;
        end else if (tick) begin
            div_cnt_r <= DIV_ZERO;
        end else if (en) begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
        end else begin
            div_cnt_r <= div_cnt_r;
        end
    end

endmodule : led_prescaler

// File: rtl/led_sequencer.sv
// led_sequencer: selectable, pausable LED pattern engine.
//   clk50     : 50 MHz clock (rising edge)
//   rst       : synchronous active-high reset
//   mode      : 0 COUNT, 1 SCAN, 2 BREATHE, 3 OFF
//   pause     : freezes prescaler and pattern (PWM keeps running)
//   leds      : registered LED drive
//   blink     : registered heartbeat, toggles on each pattern wrap
//   step_tick : registered one-cycle strobe per pattern step
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV = 16777216,
    parameter int NUM_LEDS = 6,
    parameter int PWM_BITS = 8
) (
    input  logic                clk50,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic                pause,
    output logic [NUM_LEDS-1:0] leds,
    output logic                blink,
    output logic                step_tick
);

    localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    localparam logic [NUM_LEDS-1:0] LED_ZERO = {NUM_LEDS{1'b0}};
    localparam logic [NUM_LEDS-1:0] LED_ONES = {NUM_LEDS{1'b1}};
    localparam logic [NUM_LEDS-1:0] LED_ONE  = NUM_LEDS'(1);
    localparam logic [POS_W-1:0]    POS_ZERO = POS_W'(0);
    localparam logic [POS_W-1:0]    POS_ONE  = POS_W'(1);
    localparam logic [POS_W-1:0]    POS_LAST = POS_W'(NUM_LEDS - 1);
    localparam logic [PWM_BITS-1:0] PWM_ZERO = {PWM_BITS{1'b0}};
    localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};

    led_seq_mode_t        mode_s;
    logic                 tick_s;

    led_seq_mode_t        prev_mode_r;
    logic [NUM_LEDS-1:0]  count_r;
    logic [POS_W-1:0]     pos_r;
    logic                 scan_down_r;
    logic [PWM_BITS-1:0]  duty_r;
    logic                 duty_down_r;
    logic [PWM_BITS-1:0]  pwm_cnt_r;
    logic [NUM_LEDS-1:0]  leds_r;
    logic                 blink_r;
    logic                 step_tick_r;

    logic [NUM_LEDS-1:0]  count_nxt_s;
    logic [POS_W-1:0]     pos_nxt_s;
    logic                 scan_down_nxt_s;
    logic [PWM_BITS-1:0]  duty_nxt_s;
    logic                 duty_down_nxt_s;
    logic                 blink_nxt_s;
    logic [NUM_LEDS-1:0]  leds_nxt_s;

    assign mode_s = led_seq_mode_t'(mode);

    led_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk50 (clk50),
        .rst   (rst),
        .en    (~pause),
        .tick  (tick_s)
    );

    // Pattern next state: a mode change reloads (and swallows a coincident
    // step); otherwise a step advances the active pattern.
    always_comb begin
        count_nxt_s     = count_r;
        pos_nxt_s       = pos_r;
        scan_down_nxt_s = scan_down_r;
        duty_nxt_s      = duty_r;
        duty_down_nxt_s = duty_down_r;
        blink_nxt_s     = blink_r;
        if (mode_s != prev_mode_r) begin
            count_nxt_s     = LED_ZERO;
            pos_nxt_s       = POS_ZERO;
            scan_down_nxt_s = 1'b0;
            duty_nxt_s      = PWM_ZERO;
            duty_down_nxt_s = 1'b0;
        end else if (tick_s) begin
            case (mode_s)
                MODE_COUNT: begin
                    count_nxt_s = count_r + LED_ONE;
                    if (count_r == LED_ONES) begin
                        blink_nxt_s = ~blink_r;
                    end else begin
                        blink_nxt_s = blink_r;
                    end
                end
                MODE_SCAN: begin
                    // A single LED has no travel: every step is a wrap.
                    if (NUM_LEDS == 1) begin
                        blink_nxt_s = ~blink_r;
                    end else if (!scan_down_r) begin
                        pos_nxt_s = pos_r + POS_ONE;
                        if (pos_r == POS_LAST - POS_ONE) begin
                            scan_down_nxt_s = 1'b1;
                            blink_nxt_s     = ~blink_r;
                        end else begin
                            scan_down_nxt_s = 1'b0;
                        end
                    end else begin
                        pos_nxt_s = pos_r - POS_ONE;
                        if (pos_r == POS_ONE) begin
                            scan_down_nxt_s = 1'b0;
                            blink_nxt_s     = ~blink_r;
                        end else begin
                            scan_down_nxt_s = 1'b1;
                        end
                    end
                end
                MODE_BREATHE: begin
                    if (!duty_down_r) begin
                        duty_nxt_s = duty_r + PWM_ONE;
                        if (duty_r == DUTY_MAX - PWM_ONE) begin
                            duty_down_nxt_s = 1'b1;
                            blink_nxt_s     = ~blink_r;
                        end else begin
                            duty_down_nxt_s = 1'b0;
                        end
                    end else begin
                        duty_nxt_s = duty_r - PWM_ONE;
                        if (duty_r == PWM_ONE) begin
                            duty_down_nxt_s = 1'b0;
                            blink_nxt_s     = ~blink_r;
                        end else begin
                            duty_down_nxt_s = 1'b1;
                        end
                    end
                end
                MODE_OFF: begin
                    blink_nxt_s = blink_r;
                end
                default: begin
                    blink_nxt_s = blink_r;
                end
            endcase
        end else begin
            blink_nxt_s = blink_r;
        end
    end

    // LED image from the post-edge pattern state, so leds move together
    // with step_tick.
    always_comb begin
        leds_nxt_s = LED_ZERO;
        case (mode_s)
            MODE_COUNT:   leds_nxt_s = count_nxt_s;
            MODE_SCAN:    leds_nxt_s = LED_ONE << pos_nxt_s;
            MODE_BREATHE: leds_nxt_s = (pwm_cnt_r < duty_nxt_s) ? LED_ONES : LED_ZERO;
            MODE_OFF:     leds_nxt_s = LED_ZERO;
            default:      leds_nxt_s = LED_ZERO;
        endcase
    end

    // State and output registers; reset overrides pause and mode change.
    always_ff @(posedge clk50) begin
        if (rst) begin
            prev_mode_r <= mode_s;
            count_r     <= LED_ZERO;
            pos_r       <= POS_ZERO;
            scan_down_r <= 1'b0;
            duty_r      <= PWM_ZERO;
            duty_down_r <= 1'b0;
            pwm_cnt_r   <= PWM_ZERO;
            leds_r      <= LED_ZERO;
            blink_r     <= 1'b0;
            step_tick_r <= 1'b0;
        end else begin
            prev_mode_r <= mode_s;
            count_r     <= count_nxt_s;
            pos_r       <= pos_nxt_s;
            scan_down_r <= scan_down_nxt_s;
            duty_r      <= duty_nxt_s;
            duty_down_r <= duty_down_nxt_s;
            pwm_cnt_r   <= pwm_cnt_r + PWM_ONE;
            leds_r      <= leds_nxt_s;
            blink_r     <= blink_nxt_s;
            step_tick_r <= tick_s;
        end
    end

    assign leds      = leds_r;
    assign blink     = blink_r;
    assign step_tick = step_tick_r;

endmodule : led_sequencer

// File: doc/led_sequencer.md
# led_sequencer

Parametrised LED pattern engine driving the board status LEDs and the heartbeat blink output from the 50 MHz clock. A prescaler generates one step strobe every `TICK_DIV` cycles. On each strobe a mode-selected pattern advances: binary count, bouncing scan, or PWM breathing. It replaces the fixed free-running blinker with a selectable, pausable pattern source that can be reset.

## Interface
Parameters:
- `TICK_DIV`, default 16777216: clock cycles per pattern step; legal range ≥ 2.
- `NUM_LEDS`, default 6: number of LED outputs; legal range ≥ 1.
- `PWM_BITS`, default 8: width of the breathing duty and PWM counter.

Ports:
- `clk50`, in, 1: the single clock, all logic on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `mode`, in, 2: pattern select. 0 COUNT, 1 SCAN, 2 BREATHE, 3 OFF.
- `pause`, in, 1: freezes the prescaler and pattern.
- `leds`, out, `NUM_LEDS`: LED drive, registered.
- `blink`, out, 1: heartbeat, toggles on each pattern wrap, registered.
- `step_tick`, out, 1: one-cycle strobe on each pattern step, registered.

## Operation
- Prescaler `div_cnt` counts 0 to `TICK_DIV`-1 and then wraps.
  - `step_tick` is 1 in the cycle after `div_cnt` equals `TICK_DIV`-1, provided `pause` was 0.
- `pause`=1:
  - `div_cnt` holds and no `step_tick` is generated.
  - Pattern state holds.
  - The BREATHE PWM counter keeps running, so LEDs keep their brightness.
- COUNT:
  - `count` is `NUM_LEDS` bits wide and increments by 1 per step, wrapping at modulo 2^`NUM_LEDS`.
  - `leds`=`count`.
  - `blink` toggles on the step where `count` goes from all-ones to 0.
- SCAN:
  - Position `pos` runs 0 to `NUM_LEDS`-1 with a direction bit.
  - `leds` is one-hot at bit `pos`.
  - `pos` moves ±1 per step and reverses at either end; end LEDs are not repeated.
  - `blink` toggles on each arrival at `pos`=`NUM_LEDS`-1 or at `pos`=0.
  - When `NUM_LEDS`=1, `pos` stays 0 and `blink` toggles on every step.
- BREATHE:
  - `duty` is `PWM_BITS` wide and moves ±1 per step.
  - It reverses at 2^`PWM_BITS`-1 and at 0; `blink` toggles at each reversal.
  - Free-running `pwm_cnt` is `PWM_BITS` wide.
  - All `leds` bits = (`pwm_cnt` < `duty`), so `duty`=0 means fully off and maximum duty is on (2^`PWM_BITS`-1)/2^`PWM_BITS` of the time.
- OFF: `leds`=0 and `blink` holds.
- Mode change:
  - The new `mode` is sampled every cycle.
  - When it differs from the previous `mode`, pattern state reloads to the new mode's initial state: `count`=0; `pos`=0, direction up; `duty`=0, direction up.
  - `div_cnt`, `pwm_cnt` and `blink` are not disturbed.
  - If a step and a mode change land in the same cycle, the reload wins and the step is dropped.
- Reset:
  - All registers clear: `div_cnt`=0, pattern state at COUNT initial values, `leds`=0, `blink`=0, `step_tick`=0, `pwm_cnt`=0.
  - The previous-mode register loads the current `mode`, so no reload occurs after reset.
  - Reset asserted mid-pattern takes effect on the next edge and overrides `pause` and mode change.

## Timing
- Every output is a register; there is no combinational path from any input to any output.
- First `step_tick` after reset release: in cycle `TICK_DIV` (counting the first non-reset cycle as 1), then every `TICK_DIV` cycles.
- `leds` and `blink` update in the same cycle that `step_tick` is high: the pattern advances on the edge that sets `step_tick`.
- Outputs after a mode change:
  - `leds` reflect the new mode 1 cycle after `mode` changes.
  - The first post-reset cycle shows the pattern of the current `mode`, e.g. SCAN gives `leds`=1.
- `pause` reaction: a `pause` sampled high at the `div_cnt`=`TICK_DIV`-1 edge suppresses that step. On release, counting resumes from the held `div_cnt`.

## Structure
- Package `led_seq_pkg`: the 2-bit mode enum `MODE_COUNT`, `MODE_SCAN`, `MODE_BREATHE`, `MODE_OFF`, plus a `led_seq_mode_t` typedef.
- Sub-module `led_prescaler`: parameter `TICK_DIV`, ports `clk50`, `rst`, `en`, `tick`. It holds `div_cnt` and emits a one-cycle `tick`.
- The top level contains the pattern FSM, PWM counter and output registers.

## Test plan
Bench parameters: `TICK_DIV`=4, `NUM_LEDS`=4, `PWM_BITS`=3.
1. Reset: `rst` high 2 cycles, `mode`=0. Required: during reset `leds`=0, `blink`=0, `step_tick`=0. After release, `step_tick` pulses in cycles 4, 8, 12, and `leds` is 1, 2, 3 at those cycles.
2. COUNT wrap: run 16 steps. Required: `leds` goes 1…15 then 0, and `blink` becomes 1 on the 16th step only.
3. SCAN: `mode`=1. Required: `leds` is 0001 one cycle later, then per step 0010, 0100, 1000, 0100, 0010, 0001, 0010. `blink` toggles at the 1000 step and at the 0001 step.
4. BREATHE: `mode`=2, run to `duty`=3. Required: over any 8-cycle `pwm_cnt` period, `leds`=1111 for exactly 3 cycles and 0000 for 5. `duty` reverses after reaching 7, and `blink` toggles there.
5. Pause: in COUNT at `leds`=5 with `div_cnt`=1, hold `pause` for 20 cycles. Required: `leds` stays 5 and no `step_tick` occurs. After release, `leds`=6 arrives exactly 3 cycles later.
6. Mode change and reset mid-operation:
   - Switch SCAN to COUNT at `pos`=2 in the same cycle as a step. Required: `leds`=0000 next cycle, and the step is dropped.
   - Assert `rst` at `leds`=9. Required: next cycle `leds`=0, `blink`=0, and the prescaler restarts from 0.
